ro_scan_sequencer: RTL and testbench
====================================

# ro_scan_sequencer

Sequencer for the 16-to-1 ring-oscillator output mux. It steps the mux select through the enabled oscillator channels and waits a settle period after each switch. It then counts rising edges of the muxed oscillator output over a programmable dwell window and hands each channel's count to the host over a valid/ready interface. It sits between the host control bits and the mux select input, and takes the mux output back as its measurement input.

## Interface
Parameters:
- NUM_CH, 16, number of mux channels; fixed at 16 in this design.
- SEL_W, 4, mux select width.
- DWELL_W, 16, dwell-length width, in clock cycles.
- CNT_W, 16, edge-count width.
- SETTLE_CYCLES, 8, cycles waited after each select change before counting; must be at least 4.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a scan; sampled only in IDLE.
- continuous  in  1  1 = restart the scan at the lowest enabled channel after the last one; 0 = single pass.
- abort  in  1  stops the scan and returns to IDLE.
- ch_mask  in  NUM_CH  per-channel enable; bit i = channel i. Sampled at start.
- dwell  in  DWELL_W  count-window length. Sampled at start; a value of 0 is treated as 1.
- ro_in  in  1  muxed oscillator output; asynchronous to wb_clk_i.
- mux_sel  out  SEL_W  drives the mux select.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  a result is presented.
- result_ready  in  1  host accepts the result.
- result_ch  out  SEL_W  channel number of the presented result.
- result_count  out  CNT_W  rising edges counted in the window; saturating.
- done  out  1  one-cycle pulse when a single-pass scan completes.

## Operation
- States: IDLE, SETTLE, COUNT, REPORT.
- IDLE, start=1, latched mask nonzero:
  - Latch ch_mask and dwell.
  - Set mux_sel to the lowest enabled channel.
  - Clear the settle counter and go to SETTLE.
- IDLE, start=1, mask all zero: pulse done next cycle and stay in IDLE.
- SETTLE:
  - Hold for SETTLE_CYCLES cycles so the synchronizer flushes the previous channel.
  - Clear the edge counter.
  - Go to COUNT.
- COUNT:
  - Hold for exactly the latched dwell cycles.
  - Add 1 to the edge counter in each cycle where the synchronized rise strobe is high.
  - Go to REPORT.
- REPORT:
  - result_valid=1; result_ch=mux_sel; result_count=edge counter.
  - Stay in REPORT until result_valid & result_ready.
  - On acceptance, mux_sel moves to the next enabled channel above the current one and the state goes to SETTLE.
  - If no enabled channel remains and continuous=1: wrap to the lowest enabled channel and go to SETTLE.
  - If no enabled channel remains and continuous=0: pulse done, go to IDLE.
- Synchronizer: three-flop chain s1→s2→s3 on ro_in; rise strobe = s2 & ~s3. Edges faster than wb_clk_i/2 alias; this is a known limitation.
- The edge counter saturates at 2^CNT_W−1 and never wraps.
- abort in any state:
  - Next state is IDLE; result_valid drops; no done pulse.
  - mux_sel holds its current value.
  - abort takes priority over start and over a same-cycle result acceptance.
- start while busy is ignored. ch_mask and dwell changes while busy have no effect until the next start.
- Reset (asynchronous, any time, including mid-scan):
  - State IDLE; counters cleared.
  - mux_sel=0, busy=0, result_valid=0, result_ch=0, result_count=0, done=0.

## Timing
- Cycle 0: start sampled. Cycle 1: mux_sel valid, SETTLE entered, busy=1.
- SETTLE occupies cycles 1 to SETTLE_CYCLES. COUNT occupies the next dwell cycles.
- result_valid asserts in cycle SETTLE_CYCLES+dwell+1.
- Per-channel latency, with result_ready held high: SETTLE_CYCLES + dwell + 1 cycles.
- Acceptance cycle N: mux_sel updates at N+1 and SETTLE begins at N+1.
  - On the last channel of a single pass, done=1 and busy=0 at N+1.
- result_count and result_ch are stable whenever result_valid=1.
- All outputs are registered.

## Test plan
- Mask=16'h0001, dwell=100, ro_in toggling with period 10 clocks, ready=1:
  - one result with ch=0, count=10±1;
  - done pulses once, 8+100+1+1 cycles after start.
- Mask=16'hA005, continuous=0, ready=1:
  - results arrive in order ch 0, 2, 13, 15;
  - mux_sel never shows a disabled channel; a single done pulse at the end.
- Mask=16'h0003, continuous=1, ready held low 20 cycles at each REPORT:
  - result_valid and count stay stable while ready is low;
  - the channel sequence is 0, 1, 0, 1…; done never pulses.
- Edge counter saturation:
  - with CNT_W=4, dwell=200, ro_in period 4 clocks: count=15.
  - with mask=0 and start=1: done pulses 1 cycle later and busy stays 0.
- abort during COUNT → IDLE next cycle, busy=0, no result, no done.
  - A start pulse in the same cycle as abort is ignored.
- wb_rst_i asserted mid-COUNT, asynchronous to the clock edge:
  - all outputs go to 0 immediately;
  - after reset release, a new start scans normally.

Source files
------------

// File: rtl/ro_scan_sequencer.sv
// Ring-oscillator scan sequencer: walks the mux select over enabled channels,
// settles, counts synchronized rising edges over a dwell window, reports each count.
module ro_scan_sequencer #(
  parameter int NUM_CH        = 16,
  parameter int SEL_W         = 4,
  parameter int DWELL_W       = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ro_in,
  output logic [SEL_W-1:0]   mux_sel,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [SEL_W-1:0]   result_ch,
  output logic [CNT_W-1:0]   result_count,
  output logic               done
);

  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_REPORT
  } state_t;

  state_t             r_state;
  logic [NUM_CH-1:0]  r_mask;
  logic [DWELL_W-1:0] r_dwell_len;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [ST_W-1:0]    r_settle_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic               r_s1, r_s2, r_s3;
  logic [SEL_W-1:0]   r_mux_sel;
  logic               r_busy;
  logic               r_valid;
  logic [SEL_W-1:0]   r_res_ch;
  logic [CNT_W-1:0]   r_res_cnt;
  logic               r_done;

  logic               w_rise;
  logic [CNT_W-1:0]   w_edge_inc;
  logic [DWELL_W-1:0] w_dwell_eff;
  logic               w_start_found;
  logic [SEL_W-1:0]   w_start_ch;
  logic [SEL_W-1:0]   w_first_ch;
  logic               w_next_found;
  logic [SEL_W-1:0]   w_next_ch;

  assign w_rise      = r_s2 & ~r_s3;
  assign w_edge_inc  = (r_edge_cnt == CNT_MAX) ? r_edge_cnt : r_edge_cnt + CNT_W'(w_rise);
  assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // Descending scans so the lowest qualifying channel is the last one written.
  always_comb begin
    w_start_found = 1'b0;
    w_start_ch    = '0;
    w_first_ch    = '0;
    w_next_found  = 1'b0;
    w_next_ch     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_start_found = 1'b1;
        w_start_ch    = SEL_W'(i);
      end
      if (r_mask[i]) begin
        w_first_ch = SEL_W'(i);
      end
      if (r_mask[i] && (i > int'(r_mux_sel))) begin
        w_next_found = 1'b1;
        w_next_ch    = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_dwell_len  <= '0;
      r_dwell_cnt  <= '0;
      r_settle_cnt <= '0;
      r_edge_cnt   <= '0;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_mux_sel    <= '0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_res_ch     <= '0;
      r_res_cnt    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_s1   <= ro_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_done <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (w_start_found) begin
                r_mask       <= ch_mask;
                r_dwell_len  <= w_dwell_eff;
                r_mux_sel    <= w_start_ch;
                r_settle_cnt <= '0;
                r_busy       <= 1'b1;
                r_state      <= ST_SETTLE;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_edge_cnt  <= '0;
              r_dwell_cnt <= '0;
              r_state     <= ST_COUNT;
            end else begin
              r_settle_cnt <= r_settle_cnt + ST_W'(1);
            end
          end
          ST_COUNT: begin
            r_edge_cnt <= w_edge_inc;
            // The final window cycle's strobe is folded into the reported count.
            if (r_dwell_cnt == r_dwell_len - DWELL_W'(1)) begin
              r_res_cnt <= w_edge_inc;
              r_res_ch  <= r_mux_sel;
              r_valid   <= 1'b1;
              r_state   <= ST_REPORT;
            end else begin
              r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
            end
          end
          ST_REPORT: begin
            if (result_ready) begin
              r_valid      <= 1'b0;
              r_settle_cnt <= '0;
              if (w_next_found) begin
                r_mux_sel <= w_next_ch;
                r_state   <= ST_SETTLE;
              end else if (continuous) begin
                r_mux_sel <= w_first_ch;
                r_state   <= ST_SETTLE;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mux_sel      = r_mux_sel;
  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign result_ch    = r_res_ch;
  assign result_count = r_res_cnt;
  assign done         = r_done;

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// Bench for ro_scan_sequencer: table scans, random scans against a period-based
// edge-count model, plus continuous, abort, saturation and async-reset sequences.
module tb_ro_scan_sequencer;
  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic        ro_in = 1'b0, result_ready = 1'b0;
  logic [15:0] ch_mask = '0, dwell = '0;
  logic [3:0]  mux_sel, result_ch, s_mux_sel, s_result_ch;
  logic        busy, result_valid, done, s_busy, s_valid, s_done;
  logic [15:0] result_count;
  logic [3:0]  s_count;
  int          checks = 0, errors = 0;
  int          half = 0;

  typedef struct {
    logic [15:0] mask;
    int          dwell;
    int          half;
    int          lo;
    int          hi;
  } vec_t;
  vec_t tbl[7];

  ro_scan_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .continuous(continuous),
    .abort(abort), .ch_mask(ch_mask), .dwell(dwell), .ro_in(ro_in),
    .mux_sel(mux_sel), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_ch(result_ch),
    .result_count(result_count), .done(done)
  );

  ro_scan_sequencer #(.CNT_W(4)) dut_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .continuous(continuous),
    .abort(abort), .ch_mask(ch_mask), .dwell(dwell), .ro_in(ro_in),
    .mux_sel(s_mux_sel), .busy(s_busy), .result_valid(s_valid),
    .result_ready(result_ready), .result_ch(s_result_ch),
    .result_count(s_count), .done(s_done)
  );

  always #5 clk = ~clk;

  // Oscillator: toggles every `half` clocks, 3 ns after the edge; half=0 holds it.
  initial begin
    forever begin
      @(posedge clk);
      if (half > 0) begin
        repeat (half - 1) @(posedge clk);
        #3 ro_in = ~ro_in;
      end
    end
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Rises of a period-2h square wave seen over a window of d clock samples.
  task automatic count_model(input int d, input int h, output int lo, output int hi);
    int de;
    de = (d == 0) ? 1 : d;
    if (h == 0) begin
      lo = 0;
      hi = 0;
    end else begin
      lo = de / (2 * h);
      hi = (de + 2 * h - 1) / (2 * h);
    end
  endtask

  task automatic run_scan(input logic [15:0] m, input int d, input int h, input bit cont,
                          input int hold, input int n_res, input int lo, input int hi);
    int q[$];
    int de, waited, mon_bad, unstable, exp_ch;
    logic [15:0] cnt_hold;
    de = (d == 0) ? 1 : d;
    mon_bad = 0;
    for (int i = 0; i < 16; i++) if (m[i]) q.push_back(i);
    @(negedge clk);
    ch_mask = m; dwell = d[15:0]; half = h; continuous = cont; result_ready = 0;
    repeat (6) @(negedge clk);
    start = 1;
    if (q.size() == 0) begin
      @(negedge clk);
      start = 0;
      check("empty_done", done, 1);
      check("empty_busy", busy, 0);
      @(negedge clk);
      check("empty_done_pulse", {done, busy}, 0);
      $display("scan mask=%04h: empty, done only", m);
      return;
    end
    for (int r = 0; r < n_res; r++) begin
      exp_ch = q[r % q.size()];
      waited = 0;
      do begin
        @(negedge clk);
        start = 0;
        result_ready = 0;
        waited++;
        if (!busy || done || !m[mux_sel]) mon_bad++;
      end while (!result_valid && waited < S + de + 20);
      check("latency", waited, S + de + 1);
      check("result_ch", result_ch, exp_ch);
      check_range("result_count", result_count, lo, hi);
      check_range("sat_count", s_count, imin(lo, 15), imin(hi, 15));
      $display("result mask=%04h ch=%0d count=%0d sat=%0d latency=%0d",
               m, result_ch, result_count, s_count, waited);
      if (hold > 0) begin
        unstable = 0;
        cnt_hold = result_count;
        repeat (hold) begin
          @(negedge clk);
          if (!result_valid || result_count !== cnt_hold || result_ch !== exp_ch[3:0]) unstable++;
        end
        check("hold_stable", unstable, 0);
      end
      result_ready = 1;
    end
    @(negedge clk);
    result_ready = 0;
    if (!cont) begin
      check("done_pulse", done, 1);
      check("done_idle", {busy, result_valid}, 0);
      @(negedge clk);
      check("done_single", done, 0);
    end else begin
      check("cont_busy", {busy, done}, 2);
      abort = 1;
      @(negedge clk);
      abort = 0;
      check("cont_abort", {busy, result_valid, done}, 0);
    end
    check("monitor", mon_bad, 0);
  endtask

  initial begin
    int lo, hi, bad;
    logic [15:0] m;
    int d, h;

    tbl[0] = '{16'h0001, 100, 5, 10, 10};
    tbl[1] = '{16'hA005, 20, 2, 5, 5};
    tbl[2] = '{16'h8000, 0, 0, 0, 0};
    tbl[3] = '{16'h0010, 7, 1, 3, 4};
    tbl[4] = '{16'h0000, 5, 0, 0, 0};
    tbl[5] = '{16'hFFFF, 3, 0, 0, 0};
    tbl[6] = '{16'h0001, 200, 2, 50, 50};

    repeat (2) @(negedge clk);
    check("reset_outputs", {mux_sel, busy, result_valid, result_ch, result_count, done}, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_scan(tbl[i].mask, tbl[i].dwell, tbl[i].half, 1'b0, 0, $countones(tbl[i].mask),
               tbl[i].lo, tbl[i].hi);

    // Continuous two-channel scan with a slow host.
    run_scan(16'h0003, 10, 2, 1'b1, 20, 4, 2, 3);

    // Abort mid-COUNT together with a start pulse.
    @(negedge clk);
    ch_mask = 16'h0006; dwell = 30; half = 3; continuous = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (S + 5) @(negedge clk);
    check("abort_pre_sel", mux_sel, 1);
    abort = 1; start = 1;
    @(negedge clk);
    abort = 0; start = 0;
    check("abort_idle", {busy, result_valid, done}, 0);
    check("abort_sel_hold", mux_sel, 1);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || result_valid || done) bad++;
    end
    check("abort_quiet", bad, 0);
    $display("abort during COUNT: busy=%0d valid=%0d", busy, result_valid);

    // Asynchronous reset in the middle of COUNT.
    ch_mask = 16'h0100; dwell = 40; half = 2;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (S + 10) @(negedge clk);
    check("rst_pre_busy", {busy, mux_sel}, 5'h18);
    @(posedge clk);
    #2 rst = 1;
    #1 check("rst_async_outputs", {mux_sel, busy, result_valid, result_ch, result_count, done}, 0);
    #4 rst = 0;
    $display("async reset mid-COUNT applied");
    run_scan(16'h0100, 12, 3, 1'b0, 0, 1, 2, 2);

    // Random scans against the period model.
    for (int k = 0; k < 8; k++) begin
      m = 16'($urandom & $urandom);
      d = $urandom_range(0, 40);
      h = $urandom_range(0, 5);
      count_model(d, h, lo, hi);
      run_scan(m, d, h, 1'b0, 0, $countones(m), lo, hi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
